ring_node_router: RTL and testbench
===================================

// Module: ring_node_router
// PURPOSE
//  Ring-side endpoint of the NIC network interface: one router per node of the 4-node unidirectional ring.
//  Accepts packets injected by the NIC (pesi/pedi, answers peri) and delivers packets to it (peso/pedo, reads pero).
//  Forwards transit traffic clockwise; even/odd virtual channels are selected by a global polarity bit, which is
//  driven back to the NIC. All four nodes reset together, so every router and NIC shares the same phase.
// PARAMETERS
//  DATA_W   64  packet width
//  HOP_MSB  55  MSB of hop-count field in packet
//  HOP_LSB  48  LSB of hop-count field (8-bit remaining-hops counter)
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       asynchronous, active-low; all state cleared while low
//  cwsi      in   1       send from upstream router; valid packet on cwdi
//  cwdi      in   DATA_W  packet from upstream router
//  cwri      out  1       ready to upstream: ring-input buffer of VC !polarity empty
//  cwso      out  1       send to downstream router
//  cwdo      out  DATA_W  packet to downstream router (0 when cwso=0)
//  cwro      in   1       ready from downstream router
//  pesi      in   1       NIC injects packet on pedi
//  pedi      in   DATA_W  packet from NIC
//  peri      out  1       ready to NIC: PE-input buffer of VC !polarity empty
//  peso      out  1       deliver packet to NIC
//  pedo      out  DATA_W  packet to NIC (0 when peso=0)
//  pero      in   1       NIC ready to accept delivery
//  polarity  out  1       current phase; toggles every cycle
// BEHAVIOUR
//  - Reset: polarity=0; all 4 buffers (ring_in[0/1], pe_in[0/1]) empty; cwso=peso=0, cwdo=pedo=0;
//    cwri=peri=1 (buffers empty). The first rising edge after release sets polarity=1.
//  - Phase p=polarity. During phase p, VC p buffers may only drain and VC !p buffers may only fill, so no
//    buffer is read and written in the same cycle. The packet's VC therefore alternates at every hop.
//  - Fill: if cwsi&&cwri, cwdi is written into ring_in[!p] at the clock edge. If pesi&&peri, pedi is written
//    into pe_in[!p]. A send while the matching ready is low is ignored; the sender must hold it.
//  - Eject: if ring_in[p] is full and its hop==0, then peso=1 and pedo=ring_in[p]. If pero=1 the buffer
//    frees at the edge; otherwise the packet waits 2 cycles for the next phase p.
//  - Forward candidates on cwso: ring_in[p] with hop!=0, and pe_in[p].
//    - If both exist, round-robin between them, with one last-winner bit per VC; reset favours ring_in.
//    - The winner drives cwso=1 and cwdo=packet with hop field decremented by 1; all other bits pass through.
//    - Transfer occurs only when cwro=1: the winner frees and the RR bit flips. If cwro=0, nothing frees and
//      the RR bit holds.
//  - PE injection: pe_in packets pass through unmodified except for the hop decrement. The hop field from the
//    NIC is the number of hops to the destination, where 0 means self-loop and is forbidden (behaviour undefined).
//  - Ejection and forwarding use different buffers, so both may occur in the same cycle.
//  - Hop arithmetic is 8-bit unsigned; underflow cannot occur because hop==0 is never forwarded.
//  - All outputs are combinational from registered state, polarity, and cwro/pero.
//  - Reset asserted mid-transfer: all buffers are dropped immediately; no partial packet survives.
// STRUCTURE
//  - ring_pkg: DATA_W, HOP_MSB/LSB, and function hop_dec(pkt) returning the packet with hop field minus 1.
//  - One sub-module, ring_vc_buf: 2-entry (VC0/VC1) single-packet-per-VC buffer with wr_vc/wr_en/rd_vc/rd_en
//    and full[1:0]. It is instantiated twice: once for ring input, once for PE input.
//  - Top level holds the polarity flop, 2 RR bits, and eject/forward muxing.
// TESTING
//  1. Reset low, then high: polarity toggles 0,1,0,...; cwri=peri=1, cwso=peso=0, cwdo=pedo=0.
//  2. Phase p=0, pedi hop=2, pesi=1: the packet enters pe_in[1]. Next cycle (p=1) cwso=1 with hop=1;
//     with cwro=1 it transfers and peri returns to 1.
//  3. cwdi hop=0 received at p=1 (stored in ring_in[0]): next cycle peso=1, pedo=packet. With pero=0 it
//     holds; when pero=1 on the following phase 0 it ejects.
//  4. ring_in[p] hop=3 and pe_in[p] both full, cwro=1: ring packet wins (hop=2) first, PE packet sent 2
//     cycles later.
//  5. Both VCs full while cwro=0 for 6 cycles: cwri=peri=0 in both phases, no data lost. Then cwro=1:
//     packets drain in RR order.
//  6. Reset pulled low with all buffers full: outputs return to reset values asynchronously; after release
//     no stale packet appears.

Source files
------------

// File: rtl/ring_pkg.sv
// Packet geometry and the hop-field helpers shared by the ring router
// and its testbench.
package ring_pkg;
  localparam int DATA_W  = 64;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;
  localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

  typedef enum logic {
    WIN_RING = 1'b0,
    WIN_PE   = 1'b1
  } win_e;

  // Returns the packet with only its remaining-hops field reduced by one.
  function automatic logic [DATA_W-1:0] hop_dec(input logic [DATA_W-1:0] pkt);
    logic [DATA_W-1:0] w_pkt;
    w_pkt = pkt;
    w_pkt[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - HOP_W'(1);
    return w_pkt;
  endfunction

  function automatic logic hop_zero(input logic [DATA_W-1:0] pkt);
    return pkt[HOP_MSB:HOP_LSB] == '0;
  endfunction
endpackage

// File: rtl/ring_vc_buf.sv
// Two-VC buffer holding at most one packet per virtual channel.
// One VC fills while the other drains, selected by the caller.
module ring_vc_buf
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_vc,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_vc,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        full
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_full;

  // Data is cleared too, so nothing stale is visible after a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full    <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      if (rd_en) begin
        r_full[rd_vc] <= 1'b0;
      end
      if (wr_en && !r_full[wr_vc]) begin
        r_full[wr_vc] <= 1'b1;
        r_data[wr_vc] <= wr_data;
      end
    end
  end

  assign rd_data = r_data[rd_vc];
  assign full    = r_full;

endmodule

// File: rtl/ring_node_router.sv
// One node of the 4-node unidirectional ring: accepts NIC injections,
// ejects packets with zero hops left, and forwards the rest clockwise.
module ring_node_router
  import ring_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cwsi,
  input  logic [DATA_W-1:0] cwdi,
  output logic              cwri,
  output logic              cwso,
  output logic [DATA_W-1:0] cwdo,
  input  logic              cwro,
  input  logic              pesi,
  input  logic [DATA_W-1:0] pedi,
  output logic              peri,
  output logic              peso,
  output logic [DATA_W-1:0] pedo,
  input  logic              pero,
  output logic              polarity
);

  logic              r_polarity;
  win_e              r_lastWin [2];

  logic              w_curVc;
  logic              w_fillVc;
  logic [1:0]        w_ringFull;
  logic [1:0]        w_peFull;
  logic [DATA_W-1:0] w_ringHead;
  logic [DATA_W-1:0] w_peHead;
  logic              w_ringRd;
  logic              w_peRd;
  logic              w_eject;
  logic              w_ringCand;
  logic              w_peCand;
  logic              w_fwdValid;
  logic              w_fwdXfer;
  logic [DATA_W-1:0] w_fwdPkt;
  win_e              w_winner;

  assign w_curVc  = r_polarity;
  assign w_fillVc = ~r_polarity;

  assign cwri = ~w_ringFull[w_fillVc];
  assign peri = ~w_peFull[w_fillVc];

  ring_vc_buf u_ringBuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cwsi & cwri),
    .wr_vc   (w_fillVc),
    .wr_data (cwdi),
    .rd_en   (w_ringRd),
    .rd_vc   (w_curVc),
    .rd_data (w_ringHead),
    .full    (w_ringFull)
  );

  ring_vc_buf u_peBuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pesi & peri),
    .wr_vc   (w_fillVc),
    .wr_data (pedi),
    .rd_en   (w_peRd),
    .rd_vc   (w_curVc),
    .rd_data (w_peHead),
    .full    (w_peFull)
  );

  assign w_eject    = w_ringFull[w_curVc] & hop_zero(w_ringHead);
  assign w_ringCand = w_ringFull[w_curVc] & ~hop_zero(w_ringHead);
  assign w_peCand   = w_peFull[w_curVc];
  assign w_fwdValid = w_ringCand | w_peCand;
  assign w_fwdXfer  = w_fwdValid & cwro;

  // Under contention the side that did not win last time on this VC goes next.
  always_comb begin
    w_winner = WIN_RING;
    if (w_ringCand && w_peCand) begin
      if (r_lastWin[w_curVc] == WIN_RING) begin
        w_winner = WIN_PE;
      end
    end else if (w_peCand) begin
      w_winner = WIN_PE;
    end
  end

  assign w_fwdPkt = (w_winner == WIN_RING) ? w_ringHead : w_peHead;

  assign w_ringRd = (w_eject & pero) | (w_fwdXfer & (w_winner == WIN_RING));
  assign w_peRd   = w_fwdXfer & (w_winner == WIN_PE);

  assign cwso = w_fwdValid;
  assign cwdo = w_fwdValid ? hop_dec(w_fwdPkt) : '0;
  assign peso = w_eject;
  assign pedo = w_eject ? w_ringHead : '0;

  assign polarity = r_polarity;

  // Last winner resets to PE on both VCs so the ring side is favoured first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_polarity   <= 1'b0;
      r_lastWin[0] <= WIN_PE;
      r_lastWin[1] <= WIN_PE;
    end else begin
      r_polarity <= ~r_polarity;
      if (w_fwdXfer) begin
        r_lastWin[w_curVc] <= w_winner;
      end
    end
  end

endmodule

// File: tb/tb_ring_node_router.sv
// Directed bench for ring_node_router: expected forwards/ejections go into
// queues, and a monitor compares them whenever a transfer happens.
module tb_ring_node_router;
  import ring_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cwsi = 1'b0;
  logic [DATA_W-1:0] cwdi = '0;
  logic              cwri;
  logic              cwso;
  logic [DATA_W-1:0] cwdo;
  logic              cwro = 1'b0;
  logic              pesi = 1'b0;
  logic [DATA_W-1:0] pedi = '0;
  logic              peri;
  logic              peso;
  logic [DATA_W-1:0] pedo;
  logic              pero = 1'b0;
  logic              polarity;

  int nChecks = 0;
  int nPass   = 0;
  logic [63:0] ringQ [$];
  logic [63:0] peQ   [$];

  ring_node_router dut (
    .clk      (clk),
    .reset    (reset),
    .cwsi     (cwsi),
    .cwdi     (cwdi),
    .cwri     (cwri),
    .cwso     (cwso),
    .cwdo     (cwdo),
    .cwro     (cwro),
    .pesi     (pesi),
    .pedi     (pedi),
    .peri     (peri),
    .peso     (peso),
    .pedo     (pedo),
    .pero     (pero),
    .polarity (polarity)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic cs, input logic [63:0] cd, input logic ps,
                               input logic [63:0] pd, input logic cr, input logic pr);
    @(negedge clk);
    cwsi = cs; cwdi = cd; pesi = ps; pedi = pd; cwro = cr; pero = pr;
    #2;
  endtask

  // Released shortly after a rising edge so the next cycle is still phase 0.
  task automatic applyReset();
    @(negedge clk);
    reset = 1'b0;
    cwsi = 0; cwdi = '0; pesi = 0; pedi = '0; cwro = 0; pero = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Loads VC1 (phase 0) then VC0 (phase 1) with a ring and a PE packet each.
  task automatic fillAll(input bit pushExp);
    if (pushExp) begin
      ringQ.push_back(64'h3303_0000_0000_00CC);
      ringQ.push_back(64'h1102_0000_0000_00AA);
      ringQ.push_back(64'h4401_0000_0000_00DD);
      ringQ.push_back(64'h2200_0000_0000_00BB);
    end
    applyStimulus(1, 64'h1103_0000_0000_00AA, 1, 64'h2201_0000_0000_00BB, 0, 0);
    checkOutput("fill vc1 cwri", cwri, 1);
    applyStimulus(1, 64'h3304_0000_0000_00CC, 1, 64'h4402_0000_0000_00DD, 0, 0);
    checkOutput("fill vc0 peri", peri, 1);
  endtask

  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (cwso && cwro) begin
        if (ringQ.size() > 0) checkOutput("cwdo", cwdo, ringQ.pop_front());
        else begin
          nChecks++;
          $display("[TB] FAIL cwdo unexpected: got %h, expected no transfer", cwdo);
        end
      end
      if (peso && pero) begin
        if (peQ.size() > 0) checkOutput("pedo", pedo, peQ.pop_front());
        else begin
          nChecks++;
          $display("[TB] FAIL pedo unexpected: got %h, expected no delivery", pedo);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values and polarity sequence.
    #12;
    checkOutput("rst polarity", polarity, 0);
    checkOutput("rst cwri", cwri, 1);
    checkOutput("rst peri", peri, 1);
    checkOutput("rst cwso", cwso, 0);
    checkOutput("rst peso", peso, 0);
    checkOutput("rst cwdo", cwdo, 0);
    checkOutput("rst pedo", pedo, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle polarity", polarity, 64'(i % 2));
      checkOutput("idle cwri", cwri, 1);
      checkOutput("idle peri", peri, 1);
      checkOutput("idle cwso", cwso, 0);
      checkOutput("idle peso", peso, 0);
    end

    // PE injection forwarded next phase with hop decremented.
    applyReset();
    ringQ.push_back(64'hA101_3344_5566_7788);
    applyStimulus(0, 0, 1, 64'hA102_3344_5566_7788, 0, 0);
    checkOutput("s2 polarity", polarity, 0);
    checkOutput("s2 peri", peri, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s2 cwso", cwso, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s2 peri back", peri, 1);
    checkOutput("s2 cwso after", cwso, 0);

    // Ejection held by pero=0, delivered on the following phase 0.
    applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    peQ.push_back(64'hB200_1111_2222_3333);
    applyStimulus(1, 64'hB200_1111_2222_3333, 0, 0, 0, 0);
    checkOutput("s3 cwri", cwri, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s3 peso", peso, 1);
    checkOutput("s3 pedo held", pedo, 64'hB200_1111_2222_3333);
    checkOutput("s3 no fwd", cwso, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s3 peso off phase", peso, 0);
    checkOutput("s3 pedo off phase", pedo, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("s3 peso deliver", peso, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("s3 freed", peso, 0);

    // Contention: ring packet first, PE packet two cycles later.
    applyReset();
    ringQ.push_back(64'hC302_DEAD_BEEF_0001);
    ringQ.push_back(64'hD404_0BAD_F00D_0002);
    applyStimulus(1, 64'hC303_DEAD_BEEF_0001, 1, 64'hD405_0BAD_F00D_0002, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s4 first cwdo", cwdo, 64'hC302_DEAD_BEEF_0001);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s4 gap cwso", cwso, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s4 second cwso", cwso, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s4 done cwso", cwso, 0);

    // All buffers full with back-pressure, then round-robin drain.
    applyReset();
    fillAll(1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("s5 hold cwri", cwri, 0);
      checkOutput("s5 hold peri", peri, 0);
      checkOutput("s5 hold cwso", cwso, 1);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s5 drained cwso", cwso, 0);
    checkOutput("s5 drained cwri", cwri, 1);
    checkOutput("s5 drained peri", peri, 1);

    // Asynchronous reset with everything full drops all packets.
    applyReset();
    fillAll(0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s6 full cwso", cwso, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("s6 async polarity", polarity, 0);
    checkOutput("s6 async cwso", cwso, 0);
    checkOutput("s6 async cwdo", cwdo, 0);
    checkOutput("s6 async peso", peso, 0);
    checkOutput("s6 async cwri", cwri, 1);
    checkOutput("s6 async peri", peri, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("s6 stale cwso", cwso, 0);
      checkOutput("s6 stale peso", peso, 0);
    end

    checkOutput("ringQ drained", 64'(ringQ.size()), 0);
    checkOutput("peQ drained", 64'(peQ.size()), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
